// File: rtl/tape_byte_decoder_if.sv
// Tape byte decoder bus: raw tape audio in, decoded byte stream and block status out.
interface tape_byte_decoder_if;
    logic        aud;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        block_active;
    logic        block_end;
    logic        frame_err;
    logic        pilot_lock;
    logic [15:0] byte_count;

    modport master (
        input  aud,
        output byte_data, byte_valid, block_active, block_end,
               frame_err, pilot_lock, byte_count
    );

    modport slave (
        output aud,
        input  byte_data, byte_valid, block_active, block_end,
               frame_err, pilot_lock, byte_count
    );
endinterface

// File: rtl/tape_byte_decoder.sv
// Tape byte decoder: measures rising-edge to rising-edge periods of the tape
// audio, locks onto pilot + sync, then decodes MSB-first data bits into bytes.
// A measured period is the counter value at the edge, i.e. one less than the
// edge spacing in clock cycles.
module tape_byte_decoder #(
    parameter int CLK_FREQ     = 27000000,
    parameter int PILOT_MIN_US = 1100,
    parameter int PILOT_MAX_US = 1400,
    parameter int SYNC_MIN_US  = 300,
    parameter int SYNC_MAX_US  = 440,
    parameter int BIT0_MIN_US  = 440,
    parameter int BIT0_MAX_US  = 700,
    parameter int BIT1_MIN_US  = 800,
    parameter int BIT1_MAX_US  = 1100,
    parameter int TIMEOUT_US   = 2000,
    parameter int PILOT_MIN    = 256
) (
    input logic               clk,
    input logic               reset,
    tape_byte_decoder_if.master bus
);
    localparam int          CYC_PER_US = CLK_FREQ / 1000000;
    localparam logic [23:0] PILOT_LO   = 24'(CYC_PER_US * PILOT_MIN_US);
    localparam logic [23:0] PILOT_HI   = 24'(CYC_PER_US * PILOT_MAX_US);
    localparam logic [23:0] SYNC_LO    = 24'(CYC_PER_US * SYNC_MIN_US);
    localparam logic [23:0] SYNC_HI    = 24'(CYC_PER_US * SYNC_MAX_US);
    localparam logic [23:0] BIT0_LO    = 24'(CYC_PER_US * BIT0_MIN_US);
    localparam logic [23:0] BIT0_HI    = 24'(CYC_PER_US * BIT0_MAX_US);
    localparam logic [23:0] BIT1_LO    = 24'(CYC_PER_US * BIT1_MIN_US);
    localparam logic [23:0] BIT1_HI    = 24'(CYC_PER_US * BIT1_MAX_US);
    localparam logic [23:0] TIMEOUT_TH = 24'(CYC_PER_US * TIMEOUT_US);
    localparam logic [15:0] PILOT_NEED = 16'(PILOT_MIN);
    localparam logic [23:0] CNT_MAX    = 24'hFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PILOT = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    // Lower bound inclusive, upper bound exclusive.
    function automatic logic in_window(input logic [23:0] p,
                                       input logic [23:0] lo,
                                       input logic [23:0] hi);
        return (p >= lo) && (p < hi);
    endfunction

    logic        s0_r, s1_r, s1_d_r;
    logic [23:0] cnt_r;
    state_t      state_r;
    logic        armed_r;
    logic [15:0] pilot_cnt_r;
    logic [2:0]  bit_cnt_r;
    logic [6:0]  shreg_r;

    logic [7:0]  byte_data_r;
    logic        byte_valid_r;
    logic        block_active_r;
    logic        block_end_r;
    logic        frame_err_r;
    logic        pilot_lock_r;
    logic [15:0] byte_count_r;

    logic        edge_s;
    logic        timeout_s;
    logic        is_pilot_s;
    logic        is_sync_s;
    logic        is_bit0_s;
    logic        is_bit1_s;
    logic [15:0] pilot_inc_s;

    // Synchronise the asynchronous audio input and keep one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_r   <= 1'b0;
            s1_r   <= 1'b0;
            s1_d_r <= 1'b0;
        end else begin
            s0_r   <= bus.aud;
            s1_r   <= s0_r;
            s1_d_r <= s1_r;
        end
    end

    // Period counter: restarts on every rising edge, otherwise counts up and saturates
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 24'd0;
        end else if (edge_s) begin
            cnt_r <= 24'd0;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + 24'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Edge/timeout detection and classification of the period ending at this edge
    always_comb begin
        edge_s     = s1_r & ~s1_d_r;
        timeout_s  = (cnt_r == TIMEOUT_TH) && !edge_s;
        is_pilot_s = in_window(cnt_r, PILOT_LO, PILOT_HI);
        is_sync_s  = in_window(cnt_r, SYNC_LO, SYNC_HI);
        is_bit0_s  = in_window(cnt_r, BIT0_LO, BIT0_HI);
        is_bit1_s  = in_window(cnt_r, BIT1_LO, BIT1_HI);
        if (pilot_cnt_r != 16'hFFFF) begin
            pilot_inc_s = pilot_cnt_r + 16'd1;
        end else begin
            pilot_inc_s = pilot_cnt_r;
        end
    end

    // Block framing FSM with registered byte, status and strobe outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            armed_r        <= 1'b0;
            pilot_cnt_r    <= 16'd0;
            bit_cnt_r      <= 3'd0;
            shreg_r        <= 7'd0;
            byte_data_r    <= 8'd0;
            byte_valid_r   <= 1'b0;
            block_active_r <= 1'b0;
            block_end_r    <= 1'b0;
            frame_err_r    <= 1'b0;
            pilot_lock_r   <= 1'b0;
            byte_count_r   <= 16'd0;
        end else begin
            byte_valid_r <= 1'b0;
            block_end_r  <= 1'b0;
            frame_err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (edge_s) begin
                        armed_r <= 1'b1;
                        if (armed_r && is_pilot_s) begin
                            state_r      <= ST_PILOT;
                            pilot_cnt_r  <= 16'd1;
                            pilot_lock_r <= (16'd1 >= PILOT_NEED);
                        end
                    end
                end
                ST_PILOT: begin
                    if (edge_s) begin
                        if (is_pilot_s) begin
                            pilot_cnt_r  <= pilot_inc_s;
                            pilot_lock_r <= (pilot_inc_s >= PILOT_NEED);
                        end else if (is_sync_s && (pilot_cnt_r >= PILOT_NEED)) begin
                            state_r        <= ST_DATA;
                            pilot_cnt_r    <= 16'd0;
                            pilot_lock_r   <= 1'b0;
                            bit_cnt_r      <= 3'd0;
                            shreg_r        <= 7'd0;
                            byte_count_r   <= 16'd0;
                            block_active_r <= 1'b1;
                        end else begin
                            // Short pilot, stray sync or noise: the edge re-arms IDLE
                            state_r      <= ST_IDLE;
                            armed_r      <= 1'b1;
                            pilot_cnt_r  <= 16'd0;
                            pilot_lock_r <= 1'b0;
                        end
                    end else if (timeout_s) begin
                        state_r      <= ST_IDLE;
                        armed_r      <= 1'b0;
                        pilot_cnt_r  <= 16'd0;
                        pilot_lock_r <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (edge_s && (is_bit0_s || is_bit1_s)) begin
                        shreg_r <= {shreg_r[5:0], is_bit1_s};
                        if (bit_cnt_r == 3'd7) begin
                            byte_data_r  <= {shreg_r, is_bit1_s};
                            byte_valid_r <= 1'b1;
                            byte_count_r <= byte_count_r + 16'd1;
                            bit_cnt_r    <= 3'd0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else if (edge_s || timeout_s) begin
                        // An ending edge doubles as the arming edge for the next pilot
                        state_r        <= ST_IDLE;
                        armed_r        <= edge_s;
                        block_active_r <= 1'b0;
                        block_end_r    <= 1'b1;
                        frame_err_r    <= (bit_cnt_r != 3'd0);
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    armed_r        <= 1'b0;
                    block_active_r <= 1'b0;
                    pilot_lock_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_data    = byte_data_r;
    assign bus.byte_valid   = byte_valid_r;
    assign bus.block_active = block_active_r;
    assign bus.block_end    = block_end_r;
    assign bus.frame_err    = frame_err_r;
    assign bus.pilot_lock   = pilot_lock_r;
    assign bus.byte_count   = byte_count_r;

endmodule

// File: tb/tb_tape_byte_decoder.sv
// Bench for tape_byte_decoder: one instance with the nominal timing windows for
// the literal scenarios, one with shrunken windows for long/random runs, both
// checked against a block/bit-queue reference model of the decoding rules.
module tb_tape_byte_decoder;
    localparam int CL_NONE  = 0;
    localparam int CL_PILOT = 1;
    localparam int CL_SYNC  = 2;
    localparam int CL_BIT0  = 3;
    localparam int CL_BIT1  = 4;
    localparam int BIG      = 1 << 20;
    localparam int NEED     = 16;

    logic clk;
    logic reset;
    logic aud;
    logic sel;
    int   cyc;
    int   n_vec;
    int   n_err;
    int   rise_cyc;
    int   be_cyc;

    tape_byte_decoder_if bus_a ();
    tape_byte_decoder_if bus_b ();

    assign bus_a.aud = sel ? 1'b0 : aud;
    assign bus_b.aud = sel ? aud : 1'b0;

    tape_byte_decoder #(.CLK_FREQ(1000000), .PILOT_MIN(16)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));

    tape_byte_decoder #(.CLK_FREQ(1000000),
        .PILOT_MIN_US(10), .PILOT_MAX_US(14), .SYNC_MIN_US(3), .SYNC_MAX_US(5),
        .BIT0_MIN_US(5), .BIT0_MAX_US(7), .BIT1_MIN_US(7), .BIT1_MAX_US(10),
        .TIMEOUT_US(24), .PILOT_MIN(16)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    logic [7:0]  m_data;
    logic        m_valid, m_active, m_end, m_ferr, m_lock;
    logic [15:0] m_count;
    assign m_data   = sel ? bus_b.byte_data    : bus_a.byte_data;
    assign m_valid  = sel ? bus_b.byte_valid   : bus_a.byte_valid;
    assign m_active = sel ? bus_b.block_active : bus_a.block_active;
    assign m_end    = sel ? bus_b.block_end    : bus_a.block_end;
    assign m_ferr   = sel ? bus_b.frame_err    : bus_a.frame_err;
    assign m_lock   = sel ? bus_b.pilot_lock   : bus_a.pilot_lock;
    assign m_count  = sel ? bus_b.byte_count   : bus_a.byte_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    int ref_mode;   // 0 idle, 1 pilot, 2 data
    bit ref_armed;
    int ref_pcnt;
    int ref_bc;
    bit ref_bits[$];
    int th_plo, th_phi, th_slo, th_shi, th_0lo, th_0hi, th_1lo, th_1hi, th_to;
    logic [23:0] exp_bytes[$];
    logic        exp_ends[$];
    logic [23:0] got_bytes[$];
    logic        got_ends[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Collect DUT strobes
    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid) got_bytes.push_back({m_count, m_data});
            if (m_end) begin
                got_ends.push_back(m_ferr);
                be_cyc = cyc;
                check("end_vs_valid", 32'(m_valid), 32'd0);
            end
            if (m_ferr) check("ferr_needs_end", 32'(m_end), 32'd1);
        end
    end

    function automatic int cls(input int p);
        if (p >= th_plo && p < th_phi) return CL_PILOT;
        if (p >= th_slo && p < th_shi) return CL_SYNC;
        if (p >= th_0lo && p < th_0hi) return CL_BIT0;
        if (p >= th_1lo && p < th_1hi) return CL_BIT1;
        return CL_NONE;
    endfunction

    task automatic model_reset();
        ref_mode = 0; ref_armed = 1'b0; ref_pcnt = 0; ref_bc = 0; ref_bits.delete();
    endtask

    task automatic model_edge(input int p);
        int c;
        int val;
        c = cls(p);
        if (ref_mode == 0) begin
            if (ref_armed && c == CL_PILOT) begin ref_mode = 1; ref_pcnt = 1; end
            ref_armed = 1'b1;
        end else if (ref_mode == 1) begin
            if (c == CL_PILOT) ref_pcnt = (ref_pcnt < 65535) ? ref_pcnt + 1 : 65535;
            else if (c == CL_SYNC && ref_pcnt >= NEED) begin
                ref_mode = 2; ref_bits.delete(); ref_bc = 0;
            end else begin ref_mode = 0; ref_armed = 1'b1; end
        end else begin
            if (c == CL_BIT0 || c == CL_BIT1) begin
                ref_bits.push_back(c == CL_BIT1);
                if (ref_bits.size() == 8) begin
                    val = 0;
                    foreach (ref_bits[k]) val = val * 2 + int'(ref_bits[k]);
                    ref_bc = (ref_bc + 1) % 65536;
                    exp_bytes.push_back({ref_bc[15:0], val[7:0]});
                    ref_bits.delete();
                end
            end else begin
                exp_ends.push_back(ref_bits.size() != 0);
                ref_mode = 0; ref_armed = 1'b1;
            end
        end
    endtask

    task automatic model_timeout();
        if (ref_mode == 2) exp_ends.push_back(ref_bits.size() != 0);
        if (ref_mode != 0) begin ref_mode = 0; ref_armed = 1'b0; end
    endtask

    task automatic check_state();
        check("pilot_lock", 32'(m_lock), 32'(ref_mode == 1 && ref_pcnt >= NEED));
        check("block_active", 32'(m_active), 32'(ref_mode == 2));
        check("byte_count", 32'(m_count), 32'(ref_bc));
    endtask

    task automatic check_zero();
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_active", 32'(m_active), 32'd0);
        check("rst_end", 32'(m_end), 32'd0);
        check("rst_ferr", 32'(m_ferr), 32'd0);
        check("rst_lock", 32'(m_lock), 32'd0);
        check("rst_count", 32'(m_count), 32'd0);
    endtask

    task automatic check_queues();
        check("n_bytes", 32'(got_bytes.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            check("byte", 32'(got_bytes[i]), 32'(exp_bytes[i]));
        check("n_ends", 32'(got_ends.size()), 32'(exp_ends.size()));
        for (int i = 0; i < got_ends.size() && i < exp_ends.size(); i++)
            check("frame_err", 32'(got_ends[i]), 32'(exp_ends[i]));
        got_bytes.delete(); exp_bytes.delete(); got_ends.delete(); exp_ends.delete();
    endtask

    // Rising edge p+1 cycles after the previous one, i.e. measured period p
    task automatic send(input int p);
        int h;
        h = (p + 1) / 2;
        for (int i = 1; i <= p + 1; i++) begin
            @(negedge clk);
            if (i == 3) check_state();
            if (i == p + 1) begin aud = 1'b1; rise_cyc = cyc; end
            else if (i == h) aud = 1'b0;
        end
        model_edge(p);
    endtask

    task automatic send_cls(input int c);
        int lo, hi;
        case (c)
            CL_PILOT: begin lo = th_plo; hi = th_phi; end
            CL_SYNC:  begin lo = th_slo; hi = th_shi; end
            CL_BIT0:  begin lo = th_0lo; hi = th_0hi; end
            default:  begin lo = th_1lo; hi = th_1hi; end
        endcase
        send(int'($urandom_range(hi - 1, lo)));
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int b = 7; b >= 0; b--) send_cls(v[b] ? CL_BIT1 : CL_BIT0);
    endtask

    task automatic first_edge();
        @(negedge clk);
        aud = 1'b1;
        rise_cyc = cyc;
        model_edge(BIG);
    endtask

    task automatic gap();
        for (int i = 1; i <= th_to + 10; i++) begin
            @(negedge clk);
            if (i == 2) aud = 1'b0;
            if (i == 3) check_state();
        end
        model_timeout();
    endtask

    task automatic lead_in();
        first_edge();
        repeat (17) send_cls(CL_PILOT);
        send_cls(CL_SYNC);
    endtask

    task automatic do_reset();
        repeat (4) @(negedge clk);
        aud = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic set_th(input int plo, phi, slo, shi, b0lo, b0hi, b1lo, b1hi, to);
        th_plo = plo; th_phi = phi; th_slo = slo; th_shi = shi;
        th_0lo = b0lo; th_0hi = b0hi; th_1lo = b1lo; th_1hi = b1hi; th_to = to;
    endtask

    task automatic random_block();
        int np, nbits, term;
        first_edge();
        np = int'($urandom_range(22, 8));
        for (int i = 0; i < np; i++) begin
            if ($urandom_range(15, 0) == 0) send(int'($urandom_range(22, 14)));
            else send_cls(CL_PILOT);
        end
        send_cls(CL_SYNC);
        nbits = int'($urandom_range(28, 0));
        for (int i = 0; i < nbits; i++) send_cls(($urandom_range(1, 0) == 1) ? CL_BIT1 : CL_BIT0);
        term = int'($urandom_range(2, 0));
        if (term == 1) send(int'($urandom_range(4, 3)));
        else if (term == 2) send(int'($urandom_range(20, 10)));
        gap();
        check_queues();
    endtask

    initial begin
        logic [7:0] nominal;
        n_vec = 0; n_err = 0; be_cyc = 0; rise_cyc = 0;
        aud = 1'b0; sel = 1'b0; reset = 1'b1;
        set_th(1100, 1400, 300, 440, 440, 700, 800, 1100, 2000);
        model_reset();
        repeat (3) @(negedge clk);
        check_zero();
        reset = 1'b0;

        // Nominal block at real timing: 20 pilots, sync, 0xA5, timeout
        nominal = 8'hA5;
        first_edge();
        repeat (20) send(1239);
        send(400);
        for (int b = 7; b >= 0; b--) send(nominal[b] ? 977 : 489);
        gap();
        check("timeout_latency", 32'(be_cyc - rise_cyc), 32'(3 + th_to + 1));
        check_queues();

        // Inclusive lower bounds, exclusive upper bound of the bit1 window
        first_edge();
        repeat (17) send(1100);
        send(300);
        send(440);
        send(699);
        send(800);
        send(1100);
        gap();
        check_queues();

        // Shrunken windows for the long and randomised runs
        sel = 1'b1;
        do_reset();
        check_zero();
        set_th(10, 14, 3, 5, 5, 7, 7, 10, 24);

        // Short pilot: sync refused
        first_edge();
        repeat (10) send_cls(CL_PILOT);
        send_cls(CL_SYNC);
        repeat (2) send_cls(CL_PILOT);
        gap();
        check_queues();

        // Partial byte ended by timeout
        lead_in();
        repeat (5) send_cls(($urandom_range(1, 0) == 1) ? CL_BIT1 : CL_BIT0);
        gap();
        check_queues();

        // Just below the bit0 window ends the block rather than counting as a bit
        lead_in();
        send(5);
        send(4);
        gap();
        check_queues();

        // 300 incrementing bytes, ended cleanly on a byte boundary
        lead_in();
        for (int i = 0; i < 300; i++) send_byte(8'(i));
        send(12);
        gap();
        check("byte_count_300", 32'(m_count), 32'h0000_012C);
        check_queues();

        repeat (10) random_block();

        // Reset in the middle of a block, then a fresh block
        lead_in();
        repeat (3) send_byte(8'($urandom_range(255, 0)));
        repeat (2) send_cls(CL_BIT1);
        do_reset();
        check_zero();
        repeat (3) @(negedge clk);
        check_queues();
        lead_in();
        send_byte(8'($urandom_range(255, 0)));
        gap();
        check_queues();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
